instruction_memory: RTL and testbench

- Word-addressed instruction ROM/RAM acting as the responder on the fetch-side interface.
- The fetch stage issues a PC request. This block returns the 32-bit instruction after a fixed, parameterised latency, using valid/ready handshakes on both request and response.
- A side load port lets the bench or boot logic preload the program image.
- Exactly one request is outstanding at a time; the response stalls until the consumer accepts it.

---
 rtl/cpu_pkg.sv | 16 +
 rtl/imem_array.sv | 27 ++
 rtl/instruction_memory.sv | 103 ++++++++++
 tb/tb_instruction_memory.sv | 248 ++++++++++++++++++++++++
 4 files changed

// File: rtl/cpu_pkg.sv
// Shared CPU-wide constants and types used by the fetch-side blocks.
package cpu_pkg;

    localparam int INSTR_WIDTH = 32;
    localparam int PC_WIDTH    = 32;

    // All-zero word decodes as a harmless no-op in this ISA.
    localparam logic [INSTR_WIDTH-1:0] NOP_INSTR = 32'h0000_0000;

    typedef enum logic [1:0] {
        IM_IDLE,
        IM_BUSY,
        IM_RESPOND
    } im_state_e;

endpackage

// File: rtl/imem_array.sv
// Word storage for the instruction memory: combinational read, synchronous write.
module imem_array #(
    parameter int ADDR_BITS = 8,
    parameter int DATA_W    = 32
) (
    input  logic                 clock,
    input  logic                 we_i,
    input  logic [ADDR_BITS-1:0] waddr_i,
    input  logic [DATA_W-1:0]    wdata_i,
    input  logic [ADDR_BITS-1:0] raddr_i,
    output logic [DATA_W-1:0]    rdata_o
);

    localparam int DEPTH = 1 << ADDR_BITS;

    logic [DATA_W-1:0] mem_q [DEPTH];

    // No reset: the program image must survive a CPU reset.
    always_ff @(posedge clock) begin
        if (we_i) begin
            mem_q[waddr_i] <= wdata_i;
        end
    end

    assign rdata_o = mem_q[raddr_i];

endmodule

// File: rtl/instruction_memory.sv
// Fetch-side instruction memory responder: one outstanding request, fixed
// response latency, valid/ready on both request and response.
module instruction_memory
    import cpu_pkg::*;
#(
    parameter int                     ADDR_BITS = 8,
    parameter int                     LATENCY   = 2,   // legal 1..15
    parameter logic [INSTR_WIDTH-1:0] NOP_WORD  = NOP_INSTR
) (
    input  logic                   clock,
    input  logic                   reset,
    input  logic                   req_valid,
    output logic                   req_ready,
    input  logic [PC_WIDTH-1:0]    req_pc,
    output logic                   resp_valid,
    input  logic                   resp_ready,
    output logic [INSTR_WIDTH-1:0] resp_instruction,
    output logic                   resp_error,
    input  logic                   load_enable,
    input  logic [ADDR_BITS-1:0]   load_addr,
    input  logic [INSTR_WIDTH-1:0] load_data
);

    localparam int CNT_W = 4;

    im_state_e              state_q, state_d;
    logic [CNT_W-1:0]       cnt_q, cnt_d;
    logic [INSTR_WIDTH-1:0] instr_q, instr_d;
    logic                   err_q, err_d;

    logic [ADDR_BITS-1:0]   rd_idx;
    logic [INSTR_WIDTH-1:0] rd_word;
    logic                   req_err;
    logic                   accept;

    assign rd_idx  = req_pc[ADDR_BITS+1:2];
    assign req_err = (req_pc[1:0] != 2'b00) || ((req_pc >> (ADDR_BITS + 2)) != '0);

    // Read is taken before the edge, so a same-cycle load to this word is not seen.
    imem_array #(
        .ADDR_BITS(ADDR_BITS),
        .DATA_W   (INSTR_WIDTH)
    ) u_array (
        .clock  (clock),
        .we_i   (load_enable),
        .waddr_i(load_addr),
        .wdata_i(load_data),
        .raddr_i(rd_idx),
        .rdata_o(rd_word)
    );

    assign req_ready = (state_q == IM_IDLE) && !reset;
    assign accept    = req_valid && req_ready;

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        instr_d = instr_q;
        err_d   = err_q;
        unique case (state_q)
            IM_IDLE: begin
                if (accept) begin
                    state_d = IM_BUSY;
                    cnt_d   = CNT_W'(LATENCY - 1);
                    err_d   = req_err;
                    instr_d = req_err ? NOP_WORD : rd_word;
                end
            end
            IM_BUSY: begin
                if (cnt_q == '0) begin
                    state_d = IM_RESPOND;
                end else begin
                    cnt_d = cnt_q - CNT_W'(1);
                end
            end
            IM_RESPOND: begin
                if (resp_ready) begin
                    state_d = IM_IDLE;
                end
            end
            default: state_d = IM_IDLE;
        endcase
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            state_q <= IM_IDLE;
            cnt_q   <= '0;
            instr_q <= '0;
            err_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            instr_q <= instr_d;
            err_q   <= err_d;
        end
    end

    assign resp_valid       = (state_q == IM_RESPOND);
    assign resp_instruction = instr_q;
    assign resp_error       = err_q;

endmodule

// File: tb/tb_instruction_memory.sv
// Directed bench for instruction_memory: vector table plus hand-written corner sequences.
module tb_instruction_memory;

    logic        clock = 1'b0;
    logic        reset;
    logic        req_valid;
    logic        req_ready;
    logic [31:0] req_pc;
    logic        resp_valid;
    logic        resp_ready;
    logic [31:0] resp_instruction;
    logic        resp_error;
    logic        load_enable;
    logic [7:0]  load_addr;
    logic [31:0] load_data;

    logic [1:0]  sw_req_valid;
    logic [1:0]  sw_req_ready;
    logic [1:0]  sw_resp_valid;
    logic [1:0]  sw_err;
    logic [31:0] sw_instr [2];
    logic        sw_resp_ready;

    int checks   = 0;
    int failures = 0;

    always #5 clock = ~clock;

    instruction_memory #(
        .ADDR_BITS(8),
        .LATENCY  (2),
        .NOP_WORD (32'h0000_0000)
    ) dut (
        .clock           (clock),
        .reset           (reset),
        .req_valid       (req_valid),
        .req_ready       (req_ready),
        .req_pc          (req_pc),
        .resp_valid      (resp_valid),
        .resp_ready      (resp_ready),
        .resp_instruction(resp_instruction),
        .resp_error      (resp_error),
        .load_enable     (load_enable),
        .load_addr       (load_addr),
        .load_data       (load_data)
    );

    genvar gi;
    generate
        for (gi = 0; gi < 2; gi++) begin : g_sweep
            instruction_memory #(
                .ADDR_BITS(8),
                .LATENCY  (gi == 0 ? 1 : 15)
            ) u_dut (
                .clock           (clock),
                .reset           (reset),
                .req_valid       (sw_req_valid[gi]),
                .req_ready       (sw_req_ready[gi]),
                .req_pc          (req_pc),
                .resp_valid      (sw_resp_valid[gi]),
                .resp_ready      (sw_resp_ready),
                .resp_instruction(sw_instr[gi]),
                .resp_error      (sw_err[gi]),
                .load_enable     (load_enable),
                .load_addr       (load_addr),
                .load_data       (load_data)
            );
        end
    endgenerate

    typedef struct {
        logic [31:0] pc;
        int          hold;
        logic [31:0] instr;
        logic        err;
    } vec_t;

    vec_t vecs [8];

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s actual=%h required=%h", name, act, exp);
        end
    endtask

    task automatic load_word(input logic [7:0] addr, input logic [31:0] data);
        load_enable = 1'b1;
        load_addr   = addr;
        load_data   = data;
        @(posedge clock); #1;
        load_enable = 1'b0;
    endtask

    task automatic wait_resp(output int lat);
        lat = 0;
        do begin
            @(posedge clock); #1;
            lat++;
        end while (!resp_valid && lat < 40);
    endtask

    // Full transaction on the main DUT, holding resp_ready low for 'hold' cycles.
    task automatic issue(input logic [31:0] pc, input int hold,
                         output logic [31:0] instr, output logic err, output int lat);
        int w;
        w          = 0;
        req_valid  = 1'b1;
        req_pc     = pc;
        resp_ready = 1'b0;
        while (!req_ready && w < 20) begin
            @(posedge clock); #1;
            w++;
        end
        @(posedge clock); #1;
        req_valid = 1'b0;
        wait_resp(lat);
        instr = resp_instruction;
        err   = resp_error;
        for (int i = 0; i < hold; i++) begin
            @(posedge clock); #1;
            chk("hold_valid", {31'b0, resp_valid}, 32'd1);
            chk("hold_instr", resp_instruction, instr);
            chk("hold_req_ready", {31'b0, req_ready}, 32'd0);
        end
        resp_ready = 1'b1;
        @(posedge clock); #1;
        resp_ready = 1'b0;
        chk("valid_drop", {31'b0, resp_valid}, 32'd0);
        chk("ready_back", {31'b0, req_ready}, 32'd1);
        $display("txn pc=%h instr=%h err=%b lat=%0d hold=%0d", pc, instr, err, lat, hold);
    endtask

    initial begin
        logic [31:0] instr;
        logic        err;
        int          lat;
        int          w;
        int          n;

        vecs[0] = '{32'h0000_0000, 0, 32'h8C01_0004, 1'b0};
        vecs[1] = '{32'h0000_0004, 5, 32'h0022_1820, 1'b0};
        vecs[2] = '{32'h0000_0006, 0, 32'h0000_0000, 1'b1};
        vecs[3] = '{32'h0000_0400, 0, 32'h0000_0000, 1'b1};
        vecs[4] = '{32'h0000_0008, 0, 32'hAC03_0008, 1'b0};
        vecs[5] = '{32'h0000_000C, 0, 32'h0800_0000, 1'b0};
        vecs[6] = '{32'h0000_03FC, 0, 32'h1234_5678, 1'b0};
        vecs[7] = '{32'h8000_0000, 0, 32'h0000_0000, 1'b1};

        reset         = 1'b1;
        req_valid     = 1'b0;
        req_pc        = '0;
        resp_ready    = 1'b0;
        load_enable   = 1'b0;
        load_addr     = '0;
        load_data     = '0;
        sw_req_valid  = '0;
        sw_resp_ready = 1'b1;

        // Program image is written while reset is still asserted.
        @(posedge clock); #1;
        load_word(8'd0,   32'h8C01_0004);
        load_word(8'd1,   32'h0022_1820);
        load_word(8'd2,   32'hAC03_0008);
        load_word(8'd3,   32'h0800_0000);
        load_word(8'd255, 32'h1234_5678);
        chk("reset_req_ready", {31'b0, req_ready}, 32'd0);
        chk("reset_resp_valid", {31'b0, resp_valid}, 32'd0);
        chk("reset_instr", resp_instruction, 32'd0);
        chk("reset_err", {31'b0, resp_error}, 32'd0);
        reset = 1'b0;
        @(posedge clock); #1;
        chk("post_reset_req_ready", {31'b0, req_ready}, 32'd1);

        for (int i = 0; i < 8; i++) begin
            issue(vecs[i].pc, vecs[i].hold, instr, err, lat);
            chk("vec_latency", lat, 32'd2);
            chk("vec_instr", instr, vecs[i].instr);
            chk("vec_err", {31'b0, err}, {31'b0, vecs[i].err});
        end

        // Load and accepted request to the same word in one cycle: old word wins.
        load_enable = 1'b1;
        load_addr   = 8'd2;
        load_data   = 32'hDEAD_BEEF;
        req_valid   = 1'b1;
        req_pc      = 32'h0000_0008;
        @(posedge clock); #1;
        load_enable = 1'b0;
        req_valid   = 1'b0;
        wait_resp(lat);
        chk("rbw_latency", lat, 32'd2);
        chk("rbw_old_word", resp_instruction, 32'hAC03_0008);
        $display("txn pc=00000008 instr=%h err=%b lat=%0d same-cycle-load", resp_instruction, resp_error, lat);
        resp_ready = 1'b1;
        @(posedge clock); #1;
        resp_ready = 1'b0;
        issue(32'h0000_0008, 0, instr, err, lat);
        chk("rbw_new_word", instr, 32'hDEAD_BEEF);

        // Reset one cycle after acceptance drops the pending request for good.
        req_valid = 1'b1;
        req_pc    = 32'h0000_000C;
        @(posedge clock); #1;
        req_valid = 1'b0;
        reset     = 1'b1;
        @(posedge clock); #1;
        reset = 1'b0;
        chk("midreset_valid", {31'b0, resp_valid}, 32'd0);
        n = 0;
        repeat (20) begin
            @(posedge clock); #1;
            if (resp_valid) n++;
        end
        chk("midreset_no_resp", n, 32'd0);
        $display("txn pc=0000000c dropped by reset, stray_valid_cycles=%0d", n);
        issue(32'h0000_0000, 0, instr, err, lat);
        chk("after_reset_instr", instr, 32'h8C01_0004);
        chk("after_reset_latency", lat, 32'd2);

        // Latency sweep on the LATENCY=1 and LATENCY=15 instances.
        for (int k = 0; k < 2; k++) begin
            sw_req_valid[k] = 1'b1;
            req_pc          = 32'h0000_0004;
            w = 0;
            while (!sw_req_ready[k] && w < 20) begin
                @(posedge clock); #1;
                w++;
            end
            @(posedge clock); #1;
            sw_req_valid[k] = 1'b0;
            lat = 0;
            do begin
                @(posedge clock); #1;
                lat++;
            end while (!sw_resp_valid[k] && lat < 40);
            chk("sweep_latency", lat, (k == 0) ? 32'd1 : 32'd15);
            chk("sweep_instr", sw_instr[k], 32'h0022_1820);
            $display("txn sweep k=%0d pc=00000004 instr=%h lat=%0d", k, sw_instr[k], lat);
            @(posedge clock); #1;
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
